// File: rtl/uart_pkg.sv
// uart_pkg: UART state encodings and frame constants shared by uart_tx, the arbiter and uart_rx
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT_BUSY = 2'd1, ST_WAIT_DONE = 2'd2, ST_GAP = 2'd3;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT = 1'b1;
  localparam int UART_STOP_BITS = 1;
  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] d, input logic ty);
    return ty ? ^d : ~^d;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: per-requester byte handshake between client logic and the arbiter
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req_valid, req_ready;
  logic [8*N_REQ-1:0] req_data;
  modport master(output req_valid, req_data, input req_ready);
  modport slave(input req_valid, req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotate-priority search returning the first valid index at or above ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any
);
  int best, d;
  always_comb begin
    winner = '0;
    best = N;
    d = 0;
    for (int j = 0; j < N; j++) begin
      d = (j + N - int'(ptr)) % N;
      if (valid[j] && d < best) begin
        best = d;
        winner = W'(j);
      end
    end
  end
  assign any = |valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte sources; UART_ARB_GAP_EN adds an inter-frame gap
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BUSY_TIMEOUT = 8
`ifdef UART_ARB_GAP_EN
  , parameter int GAP_CYCLES = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_arbiter_if.slave         req,
  input  logic                     cfg_par_en,
  input  logic                     cfg_par_ty,
  output logic                     tx_start,
  output logic [UART_DATA_W-1:0]   tx_data,
  output logic                     tx_par_en,
  output logic                     tx_par_ty,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     arb_busy,
  output logic                     frame_done,
  output logic                     timeout_err
);
  localparam int W = $clog2(N_REQ);
`ifdef UART_ARB_GAP_EN
  localparam int CMAX = GAP_CYCLES > BUSY_TIMEOUT ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam logic [1:0] ST_AFTER = ST_GAP;
`else
  localparam int CMAX = BUSY_TIMEOUT;
  localparam logic [1:0] ST_AFTER = ST_IDLE;
`endif
  localparam int CW = $clog2(CMAX) + 1;
  logic [1:0] state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0] rr_ptr, winner;
  logic any, grant, busy_to, done, gap_end;
  rr_arbiter #(.N(N_REQ)) u_rr (.valid(req.req_valid), .ptr(rr_ptr), .winner(winner), .any(any));
  assign grant = state == ST_IDLE && !tx_busy && any;
  assign busy_to = state == ST_WAIT_BUSY && !tx_busy && cnt == CW'(BUSY_TIMEOUT - 1);
  assign done = state == ST_WAIT_DONE && !tx_busy;
`ifdef UART_ARB_GAP_EN
  assign gap_end = state == ST_GAP && cnt == CW'(GAP_CYCLES - 1);
`else
  assign gap_end = 1'b0;
`endif
  always_comb
    state_nxt = grant ? ST_WAIT_BUSY :
                (state == ST_WAIT_BUSY && tx_busy) ? ST_WAIT_DONE :
                (busy_to || gap_end) ? ST_IDLE :
                done ? ST_AFTER : state;
  // cnt restarts on every state change; only WAIT_BUSY and GAP look at it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      rr_ptr <= '0;
      req.req_ready <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      tx_par_en <= 1'b0;
      tx_par_ty <= 1'b0;
      grant_id <= '0;
      arb_busy <= 1'b0;
      frame_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= state_nxt != state ? '0 : cnt + 1'b1;
      arb_busy <= state_nxt != ST_IDLE;
      req.req_ready <= grant ? N_REQ'(1) << winner : '0;
      tx_start <= grant;
      frame_done <= done;
      timeout_err <= busy_to;
      if (grant) begin
        tx_data <= req.req_data[{winner, 3'b000} +: UART_DATA_W];
        tx_par_en <= cfg_par_en;
        tx_par_ty <= cfg_par_ty;
        grant_id <= winner;
        rr_ptr <= winner == W'(N_REQ - 1) ? '0 : winner + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a behavioural uart_tx busy model
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int BT = 8;
  localparam int F = 10;
`ifdef UART_ARB_GAP_EN
  localparam int GAP = 16;
`else
  localparam int GAP = 0;
`endif
  typedef struct packed {logic [1:0] id; logic [7:0] data; logic pe; logic pt;} exp_t;
  logic clk = 0, rst = 1, cfg_par_en = 0, cfg_par_ty = 0, tx_busy = 0;
  logic model_en = 1, hold_busy = 0;
  logic tx_start, tx_par_en, tx_par_ty, arb_busy, frame_done, timeout_err;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  exp_t sb[$];
  int total = 0, bad = 0, busy_left = 0;

  uart_tx_arbiter_if #(.N_REQ(NR)) bus ();

  uart_tx_arbiter #(.N_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req(bus), .cfg_par_en(cfg_par_en), .cfg_par_ty(cfg_par_ty),
    .tx_start(tx_start), .tx_data(tx_data), .tx_par_en(tx_par_en), .tx_par_ty(tx_par_ty),
    .tx_busy(tx_busy), .grant_id(grant_id), .arb_busy(arb_busy), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for F cycles starting in the tx_start cycle
  always @(negedge clk) begin
    if (rst) busy_left = 0;
    else if (model_en && tx_start) busy_left = F;
    tx_busy = busy_left > 0 || hold_busy;
    if (busy_left > 0) busy_left--;
  end

  task automatic wait_sig(input int which, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((which == 0 && tx_start) || (which == 1 && frame_done) || (which == 2 && timeout_err)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1;
    bus.req_valid = '0;
    bus.req_data = '0;
    cfg_par_en = 0;
    cfg_par_ty = 0;
    hold_busy = 0;
    model_en = 1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({tx_start, tx_data, tx_par_en, tx_par_ty} !== 11'h0) begin bad++; $display("FAIL rst_tx got=%h exp=0", {tx_start, tx_data, tx_par_en, tx_par_ty}); end
    total++; if ({grant_id, arb_busy, frame_done, timeout_err} !== 5'h0) begin bad++; $display("FAIL rst_status got=%h exp=0", {grant_id, arb_busy, frame_done, timeout_err}); end
    total++; if (bus.req_ready !== 4'h0) begin bad++; $display("FAIL rst_ready got=%h exp=0", bus.req_ready); end
  endtask

  task automatic test_idle();
    logic seen = 0;
    do_reset();
    repeat (20) begin
      @(negedge clk);
      if (tx_start || arb_busy || frame_done || timeout_err || bus.req_ready != 0 || tx_data != 0) seen = 1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL idle_quiet got=%b exp=0", seen); end
  endtask

  task automatic test_single();
    int n;
    exp_t e;
    do_reset();
    cfg_par_en = 1;
    cfg_par_ty = 0;
    bus.req_data = 32'h00A5_0000;
    bus.req_valid = 4'b0100;
    sb.push_back(exp_t'{2'd2, 8'hA5, 1'b1, 1'b0});
    wait_sig(0, 20, n);
    total++;
    if (n < 0 || sb.size() == 0) begin bad++; $display("FAIL single_start got=none exp=grant"); end
    else begin
      e = sb.pop_front();
      if ({grant_id, tx_data, tx_par_en, tx_par_ty} !== e) begin bad++; $display("FAIL single_grant got=%h exp=%h", {grant_id, tx_data, tx_par_en, tx_par_ty}, e); end
      total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
    end
    bus.req_valid = '0;
    @(negedge clk);
    total++; if ({tx_start, bus.req_ready} !== 5'h0) begin bad++; $display("FAIL single_pulse got=%b exp=0", {tx_start, bus.req_ready}); end
    wait_sig(1, 40, n);
    total++; if (n !== F) begin bad++; $display("FAIL single_done_lat got=%0d exp=%0d", n, F); end
    total++; if ({tx_data, tx_par_en, tx_par_ty} !== 10'b1010_0101_10) begin bad++; $display("FAIL single_hold got=%h exp=296", {tx_data, tx_par_en, tx_par_ty}); end
    total++; if (arb_busy !== (GAP > 0)) begin bad++; $display("FAIL single_arb_busy got=%b exp=%b", arb_busy, GAP > 0); end
  endtask

  task automatic test_rotation();
    int n;
    exp_t e;
    do_reset();
    cfg_par_ty = 1;
    bus.req_data = 32'h1312_1110;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) sb.push_back(exp_t'{2'(k % 4), 8'(16 + k % 4), 1'b0, 1'b1});
    for (int k = 0; k < 5; k++) begin
      wait_sig(0, F + GAP + 30, n);
      total++;
      if (n < 0 || sb.size() == 0) begin bad++; $display("FAIL rot_start%0d got=none exp=grant", k); end
      else begin
        e = sb.pop_front();
        if ({grant_id, tx_data, tx_par_en, tx_par_ty} !== e) begin bad++; $display("FAIL rot_grant%0d got=%h exp=%h", k, {grant_id, tx_data, tx_par_en, tx_par_ty}, e); end
        if (k > 0) begin
          total++; if (n !== GAP + 1) begin bad++; $display("FAIL rot_spacing%0d got=%0d exp=%0d", k, n, GAP + 1); end
        end
      end
      if (k == 4) bus.req_valid = '0;
      wait_sig(1, F + 10, n);
      total++; if (n !== F + 1) begin bad++; $display("FAIL rot_done%0d got=%0d exp=%0d", k, n, F + 1); end
    end
  endtask

  task automatic test_wrap();
    int n;
    exp_t e;
    do_reset();
    bus.req_data = 32'h5C00_0000;
    bus.req_valid = 4'b1000;
    repeat (2) sb.push_back(exp_t'{2'd3, 8'h5C, 1'b0, 1'b0});
    for (int k = 0; k < 2; k++) begin
      wait_sig(0, F + GAP + 30, n);
      total++;
      if (n < 0 || sb.size() == 0) begin bad++; $display("FAIL wrap_start%0d got=none exp=grant", k); end
      else begin
        e = sb.pop_front();
        if ({grant_id, tx_data, tx_par_en, tx_par_ty} !== e) begin bad++; $display("FAIL wrap_grant%0d got=%h exp=%h", k, {grant_id, tx_data, tx_par_en, tx_par_ty}, e); end
      end
      if (k == 1) bus.req_valid = '0;
      wait_sig(1, F + 10, n);
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_t e;
    do_reset();
    model_en = 0;
    bus.req_data = 32'h0000_00EE;
    bus.req_valid = 4'b0001;
    repeat (2) sb.push_back(exp_t'{2'd0, 8'hEE, 1'b0, 1'b0});
    for (int k = 0; k < 2; k++) begin
      wait_sig(0, BT + 10, n);
      total++;
      if (n < 0 || sb.size() == 0) begin bad++; $display("FAIL to_start%0d got=none exp=grant", k); end
      else begin
        e = sb.pop_front();
        if ({grant_id, tx_data} !== {e.id, e.data}) begin bad++; $display("FAIL to_grant%0d got=%h exp=%h", k, {grant_id, tx_data}, {e.id, e.data}); end
        if (k == 1) begin
          total++; if (n !== 1) begin bad++; $display("FAIL to_regrant_lat got=%0d exp=1", n); end
          bus.req_valid = '0;
        end
      end
      wait_sig(2, BT + 10, n);
      total++; if (n !== BT) begin bad++; $display("FAIL to_lat%0d got=%0d exp=%0d", k, n, BT); end
      total++; if ({arb_busy, frame_done} !== 2'b00) begin bad++; $display("FAIL to_state%0d got=%b exp=00", k, {arb_busy, frame_done}); end
    end
    model_en = 1;
  endtask

  task automatic test_busy_block();
    int n;
    exp_t e;
    do_reset();
    hold_busy = 1;
    bus.req_data = 32'h0000_3C00;
    bus.req_valid = 4'b0010;
    wait_sig(0, 12, n);
    total++; if (n !== -1) begin bad++; $display("FAIL busy_block got=%0d exp=-1", n); end
    hold_busy = 0;
    sb.push_back(exp_t'{2'd1, 8'h3C, 1'b0, 1'b0});
    wait_sig(0, 10, n);
    total++;
    if (n < 0 || sb.size() == 0) begin bad++; $display("FAIL busy_release got=none exp=grant"); end
    else begin
      e = sb.pop_front();
      if ({grant_id, tx_data} !== {e.id, e.data}) begin bad++; $display("FAIL busy_grant got=%h exp=%h", {grant_id, tx_data}, {e.id, e.data}); end
    end
    bus.req_valid = '0;
    wait_sig(1, F + 10, n);
  endtask

  task automatic test_reset_mid();
    int n;
    exp_t e;
    do_reset();
    bus.req_data = 32'h0000_7700;
    bus.req_valid = 4'b0010;
    wait_sig(0, 10, n);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    total++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", arb_busy); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    total++; if ({tx_start, tx_data, tx_par_en, tx_par_ty, grant_id, arb_busy, frame_done, timeout_err, bus.req_ready} !== 20'h0) begin
      bad++; $display("FAIL mid_rst_outs got=%h exp=0", {tx_start, tx_data, tx_par_en, tx_par_ty, grant_id, arb_busy, frame_done, timeout_err, bus.req_ready});
    end
    wait_sig(1, F + 5, n);
    total++; if (n !== -1) begin bad++; $display("FAIL mid_no_done got=%0d exp=-1", n); end
    bus.req_data = 32'h1312_1110;
    bus.req_valid = 4'hF;
    sb.push_back(exp_t'{2'd0, 8'h10, 1'b0, 1'b0});
    wait_sig(0, 10, n);
    bus.req_valid = '0;
    total++;
    if (n < 0 || sb.size() == 0) begin bad++; $display("FAIL mid_start got=none exp=grant"); end
    else begin
      e = sb.pop_front();
      if ({grant_id, tx_data} !== {e.id, e.data}) begin bad++; $display("FAIL mid_ptr got=%h exp=%h", {grant_id, tx_data}, {e.id, e.data}); end
    end
    wait_sig(1, F + 10, n);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    test_reset();
    test_idle();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_busy_block();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
